fram_hd_tx: RTL

Frame-head transmitter: the sending side of the frame-head link whose receive side edge-detects and flywheel-protects an incoming head. It generates a periodic frame-head level pulse of programmable width, aligned to an internal single-cycle sync pulse. It flywheels through missing syncs and realigns after repeated misaligned syncs. It sits at the board/EPLD output, driving the head line that a remote `fram_protect`-style receiver samples.

---
 rtl/fram_hd_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fram_hd_tx.sv
// Frame-head transmitter: periodic head pulse locked to an internal sync, with flywheel.
// Define FRAM_HD_TX_REALIGN_EN to enable sync checking, miss counting, realign and head guard.
module fram_hd_tx #(
  parameter logic [25:0] FRAM_MAX = 26'd4915199,
  parameter int          HD_WIDTH = 8,
  parameter int          MISS_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_sync_hd,
  output logic        o_fram_hd,
  output logic        o_hd_pulse,
  output logic [25:0] o_fram_cnt,
  output logic        o_locked
);

  generate
    if (HD_WIDTH < 2 || 26'(HD_WIDTH) > FRAM_MAX - 26'd2) begin : g_bad_hd_width
      $error("fram_hd_tx: HD_WIDTH out of range");
    end
    if (MISS_MAX < 1 || MISS_MAX > 15) begin : g_bad_miss_max
      $error("fram_hd_tx: MISS_MAX out of range");
    end
  endgenerate

  localparam logic [25:0] HD_W = 26'(HD_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

  state_t      state_reg, state_next;
  logic [25:0] cnt_reg, cnt_next;
  logic        run_next;
  logic        hd_next;
  logic        pulse_next;
  logic        locked_next;

`ifdef FRAM_HD_TX_REALIGN_EN
  localparam logic [3:0] MISS_M = 4'(MISS_MAX);

  logic [3:0] miss_reg, miss_next;
  logic [1:0] guard_reg, guard_next;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
`ifdef FRAM_HD_TX_REALIGN_EN
    miss_next  = '0;
    guard_next = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (i_en) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (i_sync_hd) state_next = RUN;
      end
      RUN: begin
        cnt_next = (cnt_reg == FRAM_MAX) ? '0 : cnt_reg + 26'd1;
`ifdef FRAM_HD_TX_REALIGN_EN
        miss_next  = miss_reg;
        guard_next = (guard_reg != 2'd0) ? guard_reg - 2'd1 : 2'd0;
        if (i_sync_hd) begin
          if (cnt_reg == FRAM_MAX) begin
            miss_next = '0;
          end else if (miss_reg == MISS_M - 4'd1) begin
            // Realign: restart the frame; if a head is already on the line,
            // hold it low two cycles so the receiver sees a fresh edge.
            cnt_next   = '0;
            miss_next  = '0;
            guard_next = o_fram_hd ? 2'd2 : 2'd0;
          end else begin
            miss_next = miss_reg + 4'd1;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase

    // Disable overrides everything, including a coincident sync.
    if (!i_en) begin
      state_next = IDLE;
      cnt_next   = '0;
`ifdef FRAM_HD_TX_REALIGN_EN
      miss_next  = '0;
      guard_next = '0;
`endif
    end

    run_next   = (state_next == RUN);
    pulse_next = run_next && (cnt_next == 26'd0);
`ifdef FRAM_HD_TX_REALIGN_EN
    hd_next     = run_next && (cnt_next < HD_W) && (guard_next == 2'd0);
    locked_next = run_next && (miss_next == 4'd0);
`else
    hd_next     = run_next && (cnt_next < HD_W);
    locked_next = run_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      o_fram_hd  <= 1'b0;
      o_hd_pulse <= 1'b0;
      o_locked   <= 1'b0;
`ifdef FRAM_HD_TX_REALIGN_EN
      miss_reg   <= '0;
      guard_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      o_fram_hd  <= hd_next;
      o_hd_pulse <= pulse_next;
      o_locked   <= locked_next;
`ifdef FRAM_HD_TX_REALIGN_EN
      miss_reg   <= miss_next;
      guard_reg  <= guard_next;
`endif
    end
  end

  assign o_fram_cnt = cnt_reg;

endmodule
